uart_tx: RTL and testbench

Byte-wide UART transmitter: accepts one byte per valid/ready handshake and serialises it LSB-first as an 8N1 frame, or 8E1 when parity is compiled in, on a single output line. It is the transmit-side counterpart to the UART receiver on the TileLink UART peripheral, shares the same `CLKTOBAUDRATE` divisor register, and is driven directly by the peripheral's TX data register or FIFO.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_ctr.sv | 29 ++
 rtl/uart_tx.sv | 147 ++++++++++++++
 tb/tb_uart_tx.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, divisor width, data-bit count.
// Used by the transmitter now and by the receiver when it adopts it.
// No logic here beyond a small parity helper.
package uart_pkg;

  localparam int UART_DIV_W     = 12;
  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_tx_state_t;

  // Even parity over one data word (XOR of all bits).
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_ctr.sv
// Bit-period counter: counts 0..n-1 and pulses tick on the last cycle of a bit.
// Latency: tick is combinational from the registered count.
// Backpressure: none; clr forces the count back to zero.
module uart_baud_ctr
  import uart_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic [UART_DIV_W-1:0] n,
  output logic                  tick
);

  logic [UART_DIV_W-1:0] cnt;

  assign tick = (cnt == (n - {{(UART_DIV_W-1){1'b0}}, 1'b1}));

  // Free-running bit counter, wrapping at n-1, cleared on request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + {{(UART_DIV_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, LSB-first 8N1 (8E1 with UART_TX_PARITY_EN).
// Latency: line drops to the start bit 1 cycle after the transfer edge; frame is 10N (11N) cycles.
// Backpressure: o_ready only in IDLE or the last stop-bit cycle, allowing gapless back-to-back frames.
module uart_tx
  import uart_pkg::*;
(
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [UART_DIV_W-1:0]     CLKTOBAUDRATE,
  input  logic                      i_valid,
  input  logic [UART_DATA_BITS-1:0] i_byte,
  output logic                      o_ready,
  output logic                      o_busy,
  output logic                      o_tx
);

  uart_tx_state_t            state, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]                idx_q, idx_d;
  logic                      tx_q, tx_d;
  logic [UART_DIV_W-1:0]     n_q;
  logic                      tick;
  logic                      xfer;
  logic                      ctr_clr;

`ifdef UART_TX_PARITY_EN
  logic                      par_q;
`endif

  assign o_ready = (state == ST_IDLE) || ((state == ST_STOP) && tick);
  assign o_busy  = (state != ST_IDLE);
  assign o_tx    = tx_q;
  assign xfer    = i_valid && o_ready;
  // Hold the counter at zero while idle so every frame starts from a clean bit phase.
  assign ctr_clr = xfer || (state == ST_IDLE);

  uart_baud_ctr u_baud (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clr   (ctr_clr),
    .n     (n_q),
    .tick  (tick)
  );

  // Next-state and next-line decode; the line value is registered so it only moves on bit boundaries.
  always_comb begin
    state_d = state;
    shift_d = shift_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    case (state)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (xfer) begin
          state_d = ST_START;
          shift_d = i_byte;
          idx_d   = 3'd0;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = par_q;
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + 3'd1;
            tx_d    = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (xfer) begin
            state_d = ST_START;
            shift_d = i_byte;
            idx_d   = 3'd0;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State, data shifter, bit index and line register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= 3'd0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
    end
  end

  // Divisor is sampled only on a transfer so mid-frame changes cannot distort the frame.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      n_q <= 12'd2;
    end else if (xfer) begin
      n_q <= CLKTOBAUDRATE;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity of the accepted byte, computed before the shifter consumes it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      par_q <= 1'b0;
    end else if (xfer) begin
      par_q <= even_parity(i_byte);
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed scenarios plus random frames.
// Expected line values come from a frame-bit list model (start, data LSB-first, parity, stop).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic [11:0] div;
  logic        i_valid;
  logic [7:0]  i_byte;
  logic        o_ready;
  logic        o_busy;
  logic        o_tx;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] cur_b, nxt_b;
  int         cur_n, nxt_n;
  bit         ch;

  always #5 clk = ~clk;

  uart_tx dut (
    .i_clk         (clk),
    .i_rst_n       (i_rst_n),
    .CLKTOBAUDRATE (div),
    .i_valid       (i_valid),
    .i_byte        (i_byte),
    .o_ready       (o_ready),
    .o_busy        (o_busy),
    .o_tx          (o_tx)
  );

  // Bit at position pos of the serial frame for byte b.
  function automatic logic model_bit(input logic [7:0] b, input int pos);
    if (pos == 0) return 1'b0;
    else if (pos <= 8) return b[pos-1];
    else if (FRAME_BITS == 11 && pos == 9) return ^b;
    else return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic act, input logic exp);
    n_checks++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    chk({tag, " tx"},    o_tx,    1'b1);
    chk({tag, " busy"},  o_busy,  1'b0);
    chk({tag, " ready"}, o_ready, 1'b1);
  endtask

  // Present a byte while idle; returns just after the transfer edge.
  task automatic start_xfer(input logic [7:0] b, input int n);
    @(negedge clk);
    div     = n[11:0];
    i_valid = 1'b1;
    i_byte  = b;
    chk($sformatf("ready_pre_xfer b=%h", b), o_ready, 1'b1);
    @(posedge clk);
  endtask

  // Check cycles 1..upto after the transfer edge. In cycle 1 the inputs are
  // switched to (chain, nb, nd) so a following byte can be offered early.
  task automatic check_frame(input logic [7:0] b, input int n, input int upto,
                             input bit chain, input logic [7:0] nb, input int nd);
    int fl;
    fl = FRAME_BITS * n;
    for (int k = 1; k <= upto; k++) begin
      @(negedge clk);
      if (k == 1) begin
        i_valid = chain;
        i_byte  = nb;
        div     = nd[11:0];
      end
      chk($sformatf("tx b=%h n=%0d cyc=%0d", b, n, k), o_tx, model_bit(b, (k - 1) / n));
      chk($sformatf("busy b=%h n=%0d cyc=%0d", b, n, k), o_busy, 1'b1);
      chk($sformatf("ready b=%h n=%0d cyc=%0d", b, n, k), o_ready, (k == fl));
    end
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_byte  = 8'h00;
    div     = 12'd4;

    // Reset held for three cycles.
    repeat (3) begin
      @(negedge clk);
      chk("reset tx",    o_tx,    1'b1);
      chk("reset busy",  o_busy,  1'b0);
      chk("reset ready", o_ready, 1'b1);
    end
    i_rst_n = 1'b1;
    repeat (3) check_idle("post_reset");

    // Single frame, N=4.
    start_xfer(8'hA5, 4);
    check_frame(8'hA5, 4, FRAME_BITS * 4, 1'b0, 8'h00, 4);
    check_idle("after_a5");

    // Back-to-back with valid held high, N=3.
    start_xfer(8'h00, 3);
    check_frame(8'h00, 3, FRAME_BITS * 3, 1'b1, 8'hFF, 3);
    @(posedge clk);
    check_frame(8'hFF, 3, FRAME_BITS * 3, 1'b0, 8'h00, 3);
    check_idle("after_b2b");

    // Divisor changed mid-frame only affects the next transfer.
    start_xfer(8'h55, 8);
    check_frame(8'h55, 8, FRAME_BITS * 8, 1'b0, 8'h00, 2);
    check_idle("after_div8");
    start_xfer(8'h55, 2);
    check_frame(8'h55, 2, FRAME_BITS * 2, 1'b0, 8'h00, 2);
    check_idle("after_div2");

    // Reset during data bit 3 (cycles 21..25 for N=5).
    start_xfer(8'h3C, 5);
    check_frame(8'h3C, 5, 22, 1'b0, 8'h00, 5);
    i_rst_n = 1'b0;
    @(negedge clk);
    chk("midreset tx",    o_tx,    1'b1);
    chk("midreset busy",  o_busy,  1'b0);
    chk("midreset ready", o_ready, 1'b1);
    i_rst_n = 1'b1;
    check_idle("after_midreset");
    start_xfer(8'h81, 5);
    check_frame(8'h81, 5, FRAME_BITS * 5, 1'b0, 8'h00, 5);
    check_idle("after_81");

    // Parity-sensitive bytes (odd and even weight).
    start_xfer(8'h07, 4);
    check_frame(8'h07, 4, FRAME_BITS * 4, 1'b0, 8'h00, 4);
    check_idle("after_07");
    start_xfer(8'h03, 4);
    check_frame(8'h03, 4, FRAME_BITS * 4, 1'b0, 8'h00, 4);
    check_idle("after_03");

    // Random bytes, divisors and chaining.
    cur_b = 8'($urandom);
    cur_n = $urandom_range(2, 6);
    start_xfer(cur_b, cur_n);
    for (int r = 0; r < 16; r++) begin
      nxt_b = 8'($urandom);
      nxt_n = $urandom_range(2, 6);
      ch    = (r < 15) && ($urandom_range(0, 1) == 1);
      check_frame(cur_b, cur_n, FRAME_BITS * cur_n, ch, nxt_b, nxt_n);
      if (ch) begin
        @(posedge clk);
      end else begin
        check_idle("rand_idle");
        if (r < 15) start_xfer(nxt_b, nxt_n);
      end
      cur_b = nxt_b;
      cur_n = nxt_n;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
